// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/DM unified-memory port arbiter.
//   arb_state_e     : arbiter sequencing states (idle / busy / done)
//   OWN_IF, OWN_DM  : owner encoding, also the address/data mux select value
//   DEFAULT_TIMEOUT : default watchdog limit in BUSY cycles
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the memory port arbiter.
//   master modport : arbiter view (drives acks, read data and the memory strobe/mux outputs)
//   slave modport  : environment view (pipeline stages and the memory model)
interface mem_port_arbiter_if;

  // Instruction-fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;

  // Data-memory requester
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  // Memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  // Status
  logic        addr_sel;
  logic        busy;
  logic        timeout_err;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    output addr_sel, busy, timeout_err
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    input  addr_sel, busy, timeout_err
  );

endinterface

// File: rtl/arb_timeout_cnt.sv
// Watchdog counter for the memory port arbiter.
//   clk, rst : clock and asynchronous active-high reset
//   clr_i    : synchronous clear (takes precedence over en_i)
//   en_i     : count this cycle
//   tc_o     : this enabled cycle is the Timeout-th since the last clear
module arb_timeout_cnt #(
  parameter int unsigned Timeout = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  // Count holds the number of completed enabled cycles, so the Timeout-th
  // enabled cycle is seen while the count still reads Timeout-1.
  localparam logic [7:0] LastCount = 8'(Timeout - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = en_i && (count_q == LastCount);

endmodule

// File: rtl/mem_arb_mux2.sv
// Generic 2:1 mux used in front of the memory address and write-data ports.
//   sel_i : 0 selects d0_i, 1 selects d1_i
//   y_o   : selected word
module mem_arb_mux2 #(
  parameter int unsigned Width = 32
) (
  input  logic             sel_i,
  input  logic [Width-1:0] d0_i,
  input  logic [Width-1:0] d1_i,
  output logic [Width-1:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch (IF) and the
// data-memory stage (DM). One transaction at a time: grant in IDLE, wait for mem_ready
// in BUSY (with a watchdog abort), one-cycle ack with registered read data in DONE.
//   clk, rst : clock, asynchronous active-high reset
//   bus_io   : mem_port_arbiter_if.master (requesters, memory side, status)
// Parameter TIMEOUT (1..255): max BUSY cycles without mem_ready before abort.
// Build option MEM_ARB_RR_EN: ties go to the requester not served last; otherwise DM
// always wins ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus_io
);

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        busy_q, busy_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic        terr_q, terr_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  logic        grant_dm;
  logic        cnt_clr, cnt_en, cnt_tc;
  logic [31:0] mem_addr, mem_wdata;

`ifdef MEM_ARB_RR_EN
  assign grant_dm = bus_io.dm_req && (!bus_io.if_req || (last_q == OWN_IF));
`else
  // DM wins every tie so the older instruction always drains first.
  assign grant_dm = bus_io.dm_req;
  logic unused_last_served;
  assign unused_last_served = last_q;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    mem_req_d  = 1'b0;
    mem_we_d   = 1'b0;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    terr_d     = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.if_req || bus_io.dm_req) begin
          owner_d   = grant_dm ? OWN_DM : OWN_IF;
          state_d   = StBusy;
          mem_req_d = 1'b1;
          mem_we_d  = grant_dm && bus_io.dm_we;
        end
      end
      StBusy: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (bus_io.mem_ready || cnt_tc) begin
          // A response arriving in the final allowed cycle still counts as success.
          state_d = StDone;
          terr_d  = !bus_io.mem_ready;
          if (owner_q == OWN_DM) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = bus_io.mem_ready ? bus_io.mem_rdata : 32'h0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_io.mem_ready ? bus_io.mem_rdata : 32'h0;
          end
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = mem_we_q;
        end
      end
      StDone: begin
        // Requests are deliberately not sampled here; regrant happens from IDLE.
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_d = (state_d != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= OWN_IF;
      last_q     <= OWN_IF;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      terr_q     <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      terr_q     <= terr_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  arb_timeout_cnt #(
    .Timeout (TIMEOUT)
  ) u_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  mem_arb_mux2 #(
    .Width (32)
  ) u_addr_mux (
    .sel_i (owner_q),
    .d0_i  (bus_io.if_addr),
    .d1_i  (bus_io.dm_addr),
    .y_o   (mem_addr)
  );

  mem_arb_mux2 #(
    .Width (32)
  ) u_wdata_mux (
    .sel_i (owner_q),
    .d0_i  (32'h0),
    .d1_i  (bus_io.dm_wdata),
    .y_o   (mem_wdata)
  );

  assign bus_io.mem_addr    = mem_addr;
  assign bus_io.mem_wdata   = mem_wdata;
  assign bus_io.mem_req     = mem_req_q;
  assign bus_io.mem_we      = mem_we_q;
  assign bus_io.addr_sel    = owner_q;
  assign bus_io.busy        = busy_q;
  assign bus_io.if_ack      = if_ack_q;
  assign bus_io.dm_ack      = dm_ack_q;
  assign bus_io.if_rdata    = if_rdata_q;
  assign bus_io.dm_rdata    = dm_rdata_q;
  assign bus_io.timeout_err = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A transaction-level model predicts the
// winner of each grant, its cycle-by-cycle latency and the returned read data.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned TO = 15;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .TIMEOUT (TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.master)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          last_dm;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_dm_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model of the arbitration rule.
  function automatic bit pick_dm(input bit ir, input bit dr);
    if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
      return !last_dm;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  task automatic req_if(input logic [31:0] addr);
    bus.if_addr = addr;
    bus.if_req  = 1'b1;
  endtask

  task automatic req_dm(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.dm_we    = we;
    bus.dm_addr  = addr;
    bus.dm_wdata = wdata;
    bus.dm_req   = 1'b1;
  endtask

  // Called at a negedge in an IDLE cycle with requests already raised. The memory
  // answers after 'delay' extra BUSY cycles (never, if delay >= TO).
  task automatic do_txn(input int delay, input bit hold_req, input logic [31:0] rdata_val);
    bit          win_dm;
    bit          aborted;
    bit          exp_we;
    int          nb;
    logic [31:0] cap;
    logic [31:0] exp_addr;

    chk("grant_cycle_idle", bus.busy, 32'd0);
    win_dm   = pick_dm(bus.if_req, bus.dm_req);
    aborted  = (delay >= int'(TO));
    nb       = aborted ? int'(TO) : delay + 1;
    exp_addr = win_dm ? bus.dm_addr : bus.if_addr;
    exp_we   = win_dm && bus.dm_we;
    cap      = 32'h0;
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;

    for (int c = 1; c <= nb; c++) begin
      @(negedge clk);
      chk("busy_mem_req", bus.mem_req, 32'd1);
      chk("busy_addr_sel", bus.addr_sel, 32'(win_dm));
      chk("busy_mem_addr", bus.mem_addr, exp_addr);
      chk("busy_mem_we", bus.mem_we, 32'(exp_we));
      chk("busy_busy", bus.busy, 32'd1);
      chk("busy_ack", {bus.if_ack, bus.dm_ack}, 32'd0);
      if (win_dm) chk("busy_mem_wdata", bus.mem_wdata, bus.dm_wdata);
      if (c == delay + 1) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata_val;
        cap           = rdata_val;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
      end
    end
    if (win_dm) exp_dm_rdata = cap;
    else        exp_if_rdata = cap;
    last_dm = win_dm;

    @(negedge clk);
    chk("done_if_ack", bus.if_ack, 32'(!win_dm));
    chk("done_dm_ack", bus.dm_ack, 32'(win_dm));
    chk("done_if_rdata", bus.if_rdata, exp_if_rdata);
    chk("done_dm_rdata", bus.dm_rdata, exp_dm_rdata);
    chk("done_timeout_err", bus.timeout_err, 32'(aborted));
    chk("done_mem_req", bus.mem_req, 32'd0);
    chk("done_busy", bus.busy, 32'd1);
    chk("done_addr_sel", bus.addr_sel, 32'(win_dm));
    if (!hold_req) begin
      if (win_dm) bus.dm_req = 1'b0;
      else        bus.if_req = 1'b0;
    end
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;

    @(negedge clk);
    chk("idle_busy", bus.busy, 32'd0);
    chk("idle_mem_req", bus.mem_req, 32'd0);
    chk("idle_ack", {bus.if_ack, bus.dm_ack}, 32'd0);
    chk("idle_timeout_err", bus.timeout_err, 32'd0);
    chk("idle_addr_sel_held", bus.addr_sel, 32'(win_dm));
    chk("idle_if_rdata", bus.if_rdata, exp_if_rdata);
    chk("idle_dm_rdata", bus.dm_rdata, exp_dm_rdata);
    bus.mem_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, bus.mem_req, 32'd0);
    chk({tag, "_mem_we"}, bus.mem_we, 32'd0);
    chk({tag, "_busy"}, bus.busy, 32'd0);
    chk({tag, "_addr_sel"}, bus.addr_sel, 32'd0);
    chk({tag, "_acks"}, {bus.if_ack, bus.dm_ack}, 32'd0);
    chk({tag, "_terr"}, bus.timeout_err, 32'd0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
    chk({tag, "_dm_rdata"}, bus.dm_rdata, 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 32'h0;
    bus.dm_wdata  = 32'h0;
    bus.mem_rdata = 32'h0;
    bus.mem_ready = 1'b0;
    last_dm       = 1'b0;
    exp_if_rdata  = 32'h0;
    exp_dm_rdata  = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("post_reset");

    // IF only
    req_if(32'h0040_0000);
    do_txn(0, 1'b0, 32'h8C08_0004);

    // Tie: DM first, then the waiting fetch
    req_if(32'h0040_0004);
    req_dm(1'b1, 32'h1001_0000, 32'hDEAD_BEEF);
    do_txn(0, 1'b0, 32'h1111_1111);
    do_txn(0, 1'b0, 32'h2222_2222);

    // Tie right after an IF win, then a tie right after a DM win
    req_if(32'h0040_0008);
    req_dm(1'b0, 32'h1001_0004, 32'h0);
    do_txn(1, 1'b0, 32'h3333_3333);
    req_dm(1'b1, 32'h1001_0008, 32'hCAFE_F00D);
    do_txn(0, 1'b0, 32'h4444_4444);
    do_txn(2, 1'b0, 32'h5555_5555);

    // Memory answers after 4 wait cycles
    req_dm(1'b0, 32'h1001_0010, 32'h0);
    do_txn(4, 1'b0, 32'h6666_6666);

    // Boundary: answer on the last allowed cycle, then no answer at all
    req_if(32'h0040_000C);
    do_txn(int'(TO) - 1, 1'b0, 32'h7777_7777);
    req_if(32'h0040_0010);
    do_txn(1000, 1'b0, 32'h0);
    req_dm(1'b1, 32'h1001_0014, 32'h1234_5678);
    do_txn(1000, 1'b0, 32'h0);

    // Requester holds req through DONE: regranted only from the next IDLE cycle
    req_if(32'h0040_0014);
    do_txn(0, 1'b1, 32'h8888_8888);
    do_txn(0, 1'b0, 32'h9999_9999);

    // Reset in the second BUSY cycle
    req_dm(1'b0, 32'h1001_0018, 32'h0);
    do_txn(0, 1'b0, 32'hAAAA_5555);
    req_dm(1'b1, 32'h1001_001C, 32'h0BAD_F00D);
    @(negedge clk);
    chk("rst_pre_mem_req", bus.mem_req, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    bus.dm_req = 1'b0;
    @(negedge clk);
    rst          = 1'b0;
    last_dm      = 1'b0;
    exp_if_rdata = 32'h0;
    exp_dm_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_reset_outputs("rst_after");
    end

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      if (!bus.if_req && !bus.dm_req) begin
        case ($urandom_range(0, 2))
          0:       req_if($urandom);
          1:       req_dm(1'($urandom_range(0, 1)), $urandom, $urandom);
          default: begin
            req_if($urandom);
            req_dm(1'($urandom_range(0, 1)), $urandom, $urandom);
          end
        endcase
      end
      do_txn(($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3)),
             1'b0, $urandom);
    end
    while (bus.if_req || bus.dm_req) begin
      do_txn(0, 1'b0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported unified memory between the instruction-fetch stage (IF) and the data-memory stage (DM) of the MIPS pipeline. It sequences one memory transaction at a time, drives the select of the 32-bit 2:1 address/data muxes in front of the memory, and returns a one-cycle acknowledge with registered read data to the winning requester. A watchdog counter aborts transactions whose memory never answers.

## Interface
- `TIMEOUT`, 15: maximum cycles spent in BUSY waiting for `mem_ready` before abort (1..255).
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request; held high with stable `if_addr` until `if_ack`.
- `if_addr` in 32: fetch address (PC).
- `if_ack` out 1: one-cycle pulse; fetch complete.
- `if_rdata` out 32: instruction word, valid while `if_ack`=1.
- `dm_req` in 1: data request; held high with stable address/data/we until `dm_ack`.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_addr` in 32: data address.
- `dm_wdata` in 32: store data.
- `dm_ack` out 1: one-cycle pulse; data access complete.
- `dm_rdata` out 32: load data, valid while `dm_ack`=1.
- `mem_req` out 1: memory access strobe.
- `mem_we` out 1: memory write enable (0 when owner is IF).
- `mem_addr` out 32: `if_addr` when `addr_sel`=0, `dm_addr` when 1.
- `mem_wdata` out 32: `dm_wdata` (don't-care for IF).
- `mem_rdata` in 32: memory read data, sampled when `mem_ready`=1.
- `mem_ready` in 1: memory completes the access this cycle.
- `addr_sel` out 1: current owner; 0 = IF, 1 = DM.
- `busy` out 1: state ≠ IDLE.
- `timeout_err` out 1: pulses with the ack of an aborted transaction.

## Operation
- States: IDLE, BUSY, DONE. Reset: IDLE; owner = IF; last-served = IF; all outputs 0; rdata outputs 0; timeout counter 0.
- IDLE: no request → stay. Any request → latch owner, go BUSY. Only one request → that requester wins.
- Both requests (fixed priority, default): DM wins. The older instruction must complete to avoid a pipeline deadlock.
- BUSY: `mem_req`=1; `mem_we` = `dm_we` if owner is DM, else 0. Counter increments every BUSY cycle.
  - `mem_ready`=1 → capture `mem_rdata` into the owner's rdata register, go DONE.
  - Counter reaches `TIMEOUT` without `mem_ready` → rdata := 0, set the error flag, go DONE.
- DONE: the owner's ack = 1 (exactly one cycle); `timeout_err` = 1 if aborted; `mem_req`=0; update last-served; go IDLE. Requests are ignored in DONE, so the requester drops or changes `req` in this cycle.
- `addr_sel` = latched owner. It is held constant through BUSY and DONE and is changed only at a grant.
- The non-owner's ack stays 0. Its rdata holds the previous value.
- `rst` asserted mid-transaction → outputs and state return to reset values immediately. No ack is issued.

## Timing
- All outputs are registered, except `mem_addr`/`mem_wdata`, which are muxed combinationally from registered `addr_sel`.
- `req` sampled at edge 0 → `mem_req`=1 from cycle 1.
- `mem_ready`=1 in cycle k → ack=1 in cycle k+1 → IDLE in cycle k+2.
- Minimum transaction: 3 cycles (IDLE grant, BUSY, DONE). Back-to-back requests from the same requester: one grant every 3 cycles.
- Timeout: with no `mem_ready`, BUSY lasts exactly `TIMEOUT` cycles, then DONE.
- `mem_ready` outside BUSY is ignored.

## Configuration
- `MEM_ARB_RR_EN` defined: on simultaneous requests, grant the requester not in last-served. First tie after reset goes to DM, because last-served resets to IF.
- `MEM_ARB_RR_EN` undefined: fixed priority, DM always wins ties. The last-served register is still present but does not affect arbitration.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE/BUSY/DONE);
  - owner constants `OWN_IF`=0, `OWN_DM`=1;
  - default `TIMEOUT`.
- Sub-module `arb_timeout_cnt`: clear/enable counter with a terminal-count output compared against `TIMEOUT`.
- `mem_addr` and `mem_wdata` are produced by existing 2:1 32-bit mux instances selected by `addr_sel`.

## Test plan
- IF only: `if_addr`=0x00400000, `mem_ready` in the first BUSY cycle → `mem_addr`=0x00400000, `mem_we`=0. `if_ack` pulses 1 cycle later with `if_rdata`=`mem_rdata` (0x8C080004).
- Simultaneous `if_req` and `dm_req`, `dm_we`=1, `dm_addr`=0x10010000, `dm_wdata`=0xDEADBEEF:
  - DM granted first (`addr_sel`=1, `mem_we`=1), then IF.
  - With `MEM_ARB_RR_EN`, a second tie after an IF win goes to DM, and a tie after a DM win goes to IF.
- `mem_ready` delayed 4 cycles → `mem_req` high for 5 cycles, ack in cycle 6, `busy` drops in cycle 7.
- `TIMEOUT`=15, `mem_ready` never asserted → ack and `timeout_err` pulse together after 15 BUSY cycles, with rdata=0.
- `rst` pulsed in the 2nd BUSY cycle → `mem_req`, `busy` and `addr_sel` go to 0 immediately, and no ack follows.
- Requester keeps `req` high during DONE → no regrant in that cycle; a new grant occurs on the following IDLE cycle.
